hazard_stall_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage MIPS pipeline. It generates the freeze, bubble and flush controls consumed by the PC register, the IF/ID and ID/EX pipeline registers, and the fetch logic. It detects load-use hazards, holds the front end for multi-cycle EX operations, and flushes wrong-path instructions on taken branches. It also keeps a saturating stall-cycle counter for debug readout.

---
 rtl/pipeline_ctrl_pkg.sv | 29 ++
 rtl/stall_down_counter.sv | 31 +++
 rtl/hazard_stall_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline hazard/stall control
//
// Purpose : state encoding, register-field constants and the load-use helper
//           shared by hazard_stall_ctrl and its sub-modules.
// Ports   : none (package).
package pipeline_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MC_STALL = 1'b1
   } state_t;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
   localparam int CNT_W_DEF = 4;

   // A load in EX feeds a source of the instruction in ID; $zero never counts.
   function automatic logic load_use(
      input logic             mem_read,
      input logic [REG_W-1:0] ex_rt,
      input logic [REG_W-1:0] id_rs,
      input logic [REG_W-1:0] id_rt,
      input logic             uses_rt
   );
      return mem_read && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/stall_down_counter.sv
// rtl/stall_down_counter.sv - loadable down-counter with terminal flag at one
//
// Purpose : tracks the remaining cycles of a multi-cycle EX stall.
// Ports   : clk, reset (async active-low), load/load_val (load has priority),
//           dec (decrement, holds at zero), cnt (current value),
//           last (cnt == 1, i.e. this is the final stall cycle).
module stall_down_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / multi-cycle / branch hazard and stall controller
//
// Purpose : drives freeze, bubble and flush controls for the PC, IF/ID and
//           ID/EX registers of the 5-stage pipeline; counts freeze cycles.
// Macro   : FLUSH_EN - adds the IFID_Flush port, asserted on a taken branch.
// Ports   : clk, reset (async active-low)
//           id_rs, id_rt, id_uses_rt        - source fields of the ID instruction
//           ex_mem_read, ex_rt              - load in EX and its destination
//           mc_start, mc_cycles             - multi-cycle op entering EX, length N
//           branch_taken                    - EX branch resolved taken
//           PC_Freeze, IFID_Freeze, IDEX_Freeze, IDEX_Bubble, IFID_Flush
//           stall_cycles                    - saturating count of PC_Freeze cycles
module hazard_stall_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_uses_rt,
   input  logic              ex_mem_read,
   input  logic [REG_W-1:0]  ex_rt,
   input  logic              mc_start,
   input  logic [CNT_W-1:0]  mc_cycles,
   input  logic              branch_taken,
   output logic              PC_Freeze,
   output logic              IFID_Freeze,
   output logic              IDEX_Freeze,
   output logic              IDEX_Bubble,
`ifdef FLUSH_EN
   output logic              IFID_Flush,
`endif
   output logic [PERF_W-1:0] stall_cycles
);

   state_t           state, state_nxt;
   logic             cnt_load;
   logic             cnt_dec;
   logic [CNT_W-1:0] cnt_load_val;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic             lu;

   assign lu = load_use(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

   stall_down_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .last     (cnt_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      // The mc_start cycle is the first stall cycle, so N-1 remain after it.
      cnt_load_val = mc_cycles - CNT_W'(1);
      PC_Freeze    = 1'b0;
      IFID_Freeze  = 1'b0;
      IDEX_Freeze  = 1'b0;
      IDEX_Bubble  = 1'b0;
`ifdef FLUSH_EN
      IFID_Flush   = 1'b0;
`endif
      if (reset) begin
         unique case (state)
            RUN: begin
               if (branch_taken) begin
                  // Wrong-path squash beats every stall source.
                  IDEX_Bubble = 1'b1;
`ifdef FLUSH_EN
                  IFID_Flush  = 1'b1;
`endif
               end else if (mc_start && (mc_cycles > CNT_W'(1))) begin
                  PC_Freeze   = 1'b1;
                  IFID_Freeze = 1'b1;
                  IDEX_Freeze = 1'b1;
                  cnt_load    = 1'b1;
                  state_nxt   = MC_STALL;
               end else if (mc_start && (mc_cycles == CNT_W'(1))) begin
                  PC_Freeze   = 1'b1;
                  IFID_Freeze = 1'b1;
                  IDEX_Freeze = 1'b1;
               end else if (lu) begin
                  // The bubble removes the hazard by the next cycle.
                  PC_Freeze   = 1'b1;
                  IFID_Freeze = 1'b1;
                  IDEX_Bubble = 1'b1;
               end
            end
            MC_STALL: begin
               PC_Freeze   = 1'b1;
               IFID_Freeze = 1'b1;
               IDEX_Freeze = 1'b1;
               cnt_dec     = 1'b1;
               if (cnt_last) begin
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
      end else if (PC_Freeze && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  id_rs = '0;
   logic [4:0]  id_rt = '0;
   logic        id_uses_rt = 1'b0;
   logic        ex_mem_read = 1'b0;
   logic [4:0]  ex_rt = '0;
   logic        mc_start = 1'b0;
   logic [3:0]  mc_cycles = '0;
   logic        branch_taken = 1'b0;

   logic        pc_frz, ifid_frz, idex_frz, idex_bub;
   logic [31:0] sc;
   logic        s_pc_frz, s_ifid_frz, s_idex_frz, s_idex_bub;
   logic [3:0]  s_sc;
`ifdef FLUSH_EN
   logic        ifid_fl, s_ifid_fl;
`endif

   always #5 clk = ~clk;

   hazard_stall_ctrl dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .mc_start(mc_start), .mc_cycles(mc_cycles), .branch_taken(branch_taken),
      .PC_Freeze(pc_frz), .IFID_Freeze(ifid_frz), .IDEX_Freeze(idex_frz),
      .IDEX_Bubble(idex_bub),
`ifdef FLUSH_EN
      .IFID_Flush(ifid_fl),
`endif
      .stall_cycles(sc)
   );

   hazard_stall_ctrl #(.PERF_W(4)) dut_sat (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .mc_start(mc_start), .mc_cycles(mc_cycles), .branch_taken(branch_taken),
      .PC_Freeze(s_pc_frz), .IFID_Freeze(s_ifid_frz), .IDEX_Freeze(s_idex_frz),
      .IDEX_Bubble(s_idex_bub),
`ifdef FLUSH_EN
      .IFID_Flush(s_ifid_fl),
`endif
      .stall_cycles(s_sc)
   );

   typedef struct {
      int          id;
      logic [3:0]  ctl;   // {PC, IFID, IDEX freeze, IDEX bubble}
      logic        fl;
      logic [31:0] sc;
      logic [3:0]  sat;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   step_id = 0;

   // Monitor: outputs are combinational, so sample mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         total++;
         if ({pc_frz, ifid_frz, idex_frz, idex_bub} !== e.ctl) begin
            bad++;
            $display("FAIL ctl step=%0d got=%b want=%b", e.id,
                     {pc_frz, ifid_frz, idex_frz, idex_bub}, e.ctl);
         end
         total++;
         if (sc !== e.sc) begin
            bad++;
            $display("FAIL stall_cycles step=%0d got=%0d want=%0d", e.id, sc, e.sc);
         end
         total++;
         if (s_sc !== e.sat) begin
            bad++;
            $display("FAIL sat_cycles step=%0d got=%0d want=%0d", e.id, s_sc, e.sat);
         end
         total++;
         if ({s_pc_frz, s_ifid_frz, s_idex_frz, s_idex_bub} !== e.ctl) begin
            bad++;
            $display("FAIL sat_ctl step=%0d got=%b want=%b", e.id,
                     {s_pc_frz, s_ifid_frz, s_idex_frz, s_idex_bub}, e.ctl);
         end
`ifdef FLUSH_EN
         total++;
         if (ifid_fl !== e.fl) begin
            bad++;
            $display("FAIL flush step=%0d got=%b want=%b", e.id, ifid_fl, e.fl);
         end
`endif
      end
   end

   // Drive one cycle of inputs just after the edge, and queue what must be seen.
   task automatic step(input logic rst, input logic rd, input logic [4:0] ert,
                       input logic [4:0] irs, input logic [4:0] irt, input logic urt,
                       input logic mcs, input logic [3:0] mcn, input logic br,
                       input logic [3:0] ectl, input logic efl, input int esc);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; ex_mem_read = rd; ex_rt = ert; id_rs = irs; id_rt = irt;
      id_uses_rt = urt; mc_start = mcs; mc_cycles = mcn; branch_taken = br;
      step_id++;
      e.id  = step_id;
      e.ctl = ectl;
      e.fl  = efl;
      e.sc  = 32'(esc);
      e.sat = (esc > 15) ? 4'd15 : 4'(esc);
      exp_q.push_back(e);
   endtask

   localparam logic [3:0] NONE = 4'b0000;
   localparam logic [3:0] LU   = 4'b1101;
   localparam logic [3:0] MC   = 4'b1110;
   localparam logic [3:0] BR   = 4'b0001;

   initial begin
      //   rst rd  ert  irs  irt urt mcs mcn br   ctl   fl  sc
      step(0, 1, 8,   8,   0,  0,  1,  4, 0,  NONE, 0,  0);  // held in reset
      step(1, 0, 0,   0,   0,  0,  0,  0, 0,  NONE, 0,  0);
      step(1, 1, 8,   8,   0,  0,  0,  0, 0,  LU,   0,  0);  // lu on rs
      step(1, 0, 0,   0,   0,  0,  0,  0, 0,  NONE, 0,  1);
      step(1, 1, 9,   3,   9,  1,  0,  0, 0,  LU,   0,  1);  // lu on rt
      step(1, 1, 9,   3,   9,  0,  0,  0, 0,  NONE, 0,  2);  // rt not a source
      step(1, 1, 0,   0,   0,  1,  0,  0, 0,  NONE, 0,  2);  // $zero guard
      step(1, 1, 8,   8,   0,  0,  1,  4, 0,  MC,   0,  2);  // mc N=4 beats lu
      step(1, 1, 8,   8,   0,  0,  0,  0, 1,  MC,   0,  3);  // branch/lu ignored
      step(1, 0, 0,   0,   0,  0,  1,  2, 0,  MC,   0,  4);
      step(1, 0, 0,   0,   0,  0,  0,  0, 0,  MC,   0,  5);  // 4th and last
      step(1, 1, 8,   8,   0,  0,  0,  0, 0,  LU,   0,  6);  // lu re-evaluated
      step(1, 0, 0,   0,   0,  0,  0,  0, 0,  NONE, 0,  7);
      step(1, 1, 8,   8,   0,  0,  0,  0, 1,  BR,   1,  7);  // branch over lu
      step(1, 0, 0,   0,   0,  0,  1,  3, 1,  BR,   1,  7);  // branch over mc
      step(1, 0, 0,   0,   0,  0,  0,  0, 0,  NONE, 0,  7);
      step(1, 0, 0,   0,   0,  0,  1,  1, 0,  MC,   0,  7);  // N=1
      step(1, 0, 0,   0,   0,  0,  0,  0, 0,  NONE, 0,  8);
      step(1, 1, 8,   8,   0,  0,  1,  0, 0,  LU,   0,  8);  // N=0 falls to lu
      step(1, 0, 0,   0,   0,  0,  0,  0, 0,  NONE, 0,  9);
      step(1, 0, 0,   0,   0,  0,  1,  8, 0,  MC,   0,  9);  // N=8
      step(1, 0, 0,   0,   0,  0,  0,  0, 0,  MC,   0, 10);
      step(1, 0, 0,   0,   0,  0,  0,  0, 0,  MC,   0, 11);
      step(0, 0, 0,   0,   0,  0,  0,  0, 0,  NONE, 0,  0);  // reset mid-stall
      step(1, 0, 0,   0,   0,  0,  0,  0, 0,  NONE, 0,  0);  // back in RUN
      step(1, 0, 0,   0,   0,  0,  0,  0, 0,  NONE, 0,  0);
      // 20 consecutive freeze cycles: N=15 then N=5.
      for (int i = 0; i < 15; i++) begin
         step(1, 0, 0, 0, 0, 0, (i == 0), 4'd15, 0, MC, 0, i);
      end
      step(1, 0, 0, 0, 0, 0, 1, 4'd5, 0, MC, 0, 15);
      for (int i = 16; i < 20; i++) begin
         step(1, 0, 0, 0, 0, 0, 0, 4'd0, 0, MC, 0, i);
      end
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 20);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 20);

      repeat (4) @(posedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
